// File: rtl/psdram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psdram_pkg
//  Description : Shared types and default timing constants for the PSDRAM
//                arbiter: FSM state encoding, requester identifiers, and
//                default access/recovery/burst settings.
//  Revision    : 1.0 - initial release
// ============================================================================
package psdram_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Requester identity of the granted / in-flight transaction
    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_id_t;

    // Default timing at 50 MHz: 4 x 20 ns = 80 ns covers 70 ns tAA/tWP
    localparam int unsigned DEF_ACCESS_CYCLES   = 4;
    localparam int unsigned DEF_RECOVERY_CYCLES = 1;
    localparam int unsigned DEF_MAX_RD_BURST    = 8;

endpackage
`default_nettype wire

// File: rtl/psdram_grant_sel.sv
`default_nettype none
// ============================================================================
//  Module      : psdram_grant_sel
//  Description : Priority decision between the video read port and the UART
//                write port. Reads win by default. When the macro
//                PSDRAM_ARB_STARVE_GUARD_EN is defined, a counter of read
//                grants issued while a write waits forces a write grant once
//                it reaches MAX_RD_BURST.
//  Ports       : clk, nRst          - clock, async active-low reset
//                rd_req, wr_req    - qualified requests
//                take              - a grant is consumed this cycle (IDLE)
//                grant_valid       - some requester is present
//                grant_id          - which requester would be granted
//  Revision    : 1.0 - initial release
// ============================================================================
module psdram_grant_sel
    import psdram_pkg::*;
#(
    parameter int unsigned MAX_RD_BURST = DEF_MAX_RD_BURST
) (
    input  logic    clk,
    input  logic    nRst,
    input  logic    rd_req,
    input  logic    wr_req,
    input  logic    take,
    output logic    grant_valid,
    output req_id_t grant_id
);

    assign grant_valid = rd_req | wr_req;

`ifdef PSDRAM_ARB_STARVE_GUARD_EN
    localparam int unsigned BURST_W = $clog2(MAX_RD_BURST + 1);

    logic [BURST_W-1:0] burst_cnt;
    logic               starved;

    assign starved = (burst_cnt >= BURST_W'(MAX_RD_BURST));

    always_comb begin
        grant_id = REQ_RD;
        if (wr_req && (!rd_req || starved)) begin
            grant_id = REQ_WR;
        end
    end

    // Counts read grants only while a write is waiting; any write grant or
    // an absent write request restarts the count.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            burst_cnt <= '0;
        end else if (!wr_req) begin
            burst_cnt <= '0;
        end else if (take) begin
            if (grant_id == REQ_WR) begin
                burst_cnt <= '0;
            end else if (!starved) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end
`else
    // Strict read priority: a write is granted only with no read pending.
    always_comb begin
        grant_id = REQ_RD;
        if (wr_req && !rd_req) begin
            grant_id = REQ_WR;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, nRst, take, MAX_RD_BURST[0]};
`endif

endmodule
`default_nettype wire

// File: rtl/psdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : psdram_arbiter
//  Description : Two-port arbiter and asynchronous cycle sequencer for a
//                16-bit pseudo-static DRAM. Grants the video read port or the
//                UART write port, drives registered CE/OE/WE/UB/LB strobes for
//                ACCESS_CYCLES, holds all strobes high for RECOVERY_CYCLES,
//                and returns a one-cycle RdAck/WrAck.
//                Optional feature macro: PSDRAM_ARB_STARVE_GUARD_EN (read
//                burst limit while a write waits, see psdram_grant_sel).
//  Ports       : clk, nRst                      - clock, async active-low reset
//                RdReq/RdAdr/RdData/RdAck       - video read port
//                WrReq/WrAdr/WrData/WrByteEn/WrAck - UART write port
//                Busy                           - sequencer not idle
//                nRamCE/nMemOE/nMemWR/nRamUB/nRamLB - PSDRAM strobes
//                MemAdr, MemDataOut, MemDataOe, MemDataIn - PSDRAM bus
//                RamADV/RamClk/RamCRE           - tied low (async mode)
//  Revision    : 1.0 - initial release
// ============================================================================
module psdram_arbiter
    import psdram_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES   = DEF_ACCESS_CYCLES,
    parameter int unsigned RECOVERY_CYCLES = DEF_RECOVERY_CYCLES,
    parameter int unsigned MAX_RD_BURST    = DEF_MAX_RD_BURST
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        RdReq,
    input  logic [22:0] RdAdr,
    output logic [15:0] RdData,
    output logic        RdAck,
    input  logic        WrReq,
    input  logic [22:0] WrAdr,
    input  logic [15:0] WrData,
    input  logic [1:0]  WrByteEn,
    output logic        WrAck,
    output logic        Busy,
    output logic        nRamCE,
    output logic        nMemOE,
    output logic        nMemWR,
    output logic        nRamUB,
    output logic        nRamLB,
    output logic [22:0] MemAdr,
    output logic [15:0] MemDataOut,
    output logic        MemDataOe,
    input  logic [15:0] MemDataIn,
    output logic        RamADV,
    output logic        RamClk,
    output logic        RamCRE
);

    localparam int unsigned MAX_CYC = (ACCESS_CYCLES > RECOVERY_CYCLES) ?
                                      ACCESS_CYCLES : RECOVERY_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVERY_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_id_t          cur_q, cur_d;

    logic        ce_d, oe_d, wr_d, ub_d, lb_d, pad_oe_d;
    logic [22:0] adr_d;
    logic [15:0] dout_d, rd_data_d;
    logic        rd_ack_d, wr_ack_d;

    logic        take;
    logic        grant_valid;
    req_id_t     grant_id;
    logic        wr_req_q;

    // A zero-byte-enable write is acknowledged while still in IDLE; masking
    // the request during that ack cycle keeps it from being served twice.
    assign wr_req_q = WrReq & ~WrAck;

    psdram_grant_sel #(
        .MAX_RD_BURST (MAX_RD_BURST)
    ) u_grant_sel (
        .clk         (clk),
        .nRst        (nRst),
        .rd_req      (RdReq),
        .wr_req      (wr_req_q),
        .take        (take),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign Busy   = (state_q != ST_IDLE);
    assign RamADV = 1'b0;
    assign RamClk = 1'b0;
    assign RamCRE = 1'b0;

    // State and pin registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_q      <= REQ_RD;
            nRamCE     <= 1'b1;
            nMemOE     <= 1'b1;
            nMemWR     <= 1'b1;
            nRamUB     <= 1'b1;
            nRamLB     <= 1'b1;
            MemAdr     <= '0;
            MemDataOut <= '0;
            MemDataOe  <= 1'b0;
            RdData     <= '0;
            RdAck      <= 1'b0;
            WrAck      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            nRamCE     <= ce_d;
            nMemOE     <= oe_d;
            nMemWR     <= wr_d;
            nRamUB     <= ub_d;
            nRamLB     <= lb_d;
            MemAdr     <= adr_d;
            MemDataOut <= dout_d;
            MemDataOe  <= pad_oe_d;
            RdData     <= rd_data_d;
            RdAck      <= rd_ack_d;
            WrAck      <= wr_ack_d;
        end
    end

    // Next-state and next-pin logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_d     = cur_q;
        ce_d      = nRamCE;
        oe_d      = nMemOE;
        wr_d      = nMemWR;
        ub_d      = nRamUB;
        lb_d      = nRamLB;
        adr_d     = MemAdr;
        dout_d    = MemDataOut;
        pad_oe_d  = MemDataOe;
        rd_data_d = RdData;
        rd_ack_d  = 1'b0;
        wr_ack_d  = 1'b0;
        take      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    take = 1'b1;
                    if (grant_id == REQ_RD) begin
                        adr_d    = RdAdr;
                        ce_d     = 1'b0;
                        oe_d     = 1'b0;
                        wr_d     = 1'b1;
                        ub_d     = 1'b0;
                        lb_d     = 1'b0;
                        pad_oe_d = 1'b0;
                        cnt_d    = ACC_LOAD;
                        cur_d    = REQ_RD;
                        state_d  = ST_ACCESS;
                    end else if (WrByteEn == 2'b00) begin
                        // Nothing to write: acknowledge without a bus cycle
                        wr_ack_d = 1'b1;
                    end else begin
                        adr_d          = WrAdr;
                        dout_d         = WrData;
                        ce_d           = 1'b0;
                        oe_d           = 1'b1;
                        wr_d           = 1'b0;
                        {ub_d, lb_d}   = ~WrByteEn;
                        pad_oe_d       = 1'b1;
                        cnt_d          = ACC_LOAD;
                        cur_d          = REQ_WR;
                        state_d        = ST_ACCESS;
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    if (cur_q == REQ_RD) begin
                        rd_data_d = MemDataIn;
                        rd_ack_d  = 1'b1;
                    end else begin
                        wr_ack_d  = 1'b1;
                    end
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    wr_d    = 1'b1;
                    ub_d    = 1'b1;
                    lb_d    = 1'b1;
                    cnt_d   = REC_LOAD;
                    state_d = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RECOVER: begin
                // Pad enable stays as-is here so write data is held through
                // the recovery gap.
                if (cnt_q == '0) begin
                    pad_oe_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
